// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and a
// helper that sizes the bit counter from the operand width.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Number of bits needed to count 0..value-1, never less than one.
   function automatic int counterWidth(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// Combinational full-subtractor cell: one bit of x - y - bin.
module fs_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow-out of a single-bit subtraction with borrow-in.
   always_comb begin
      d    = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first.
// Optional macro SERIAL_SUB_SAT_EN saturates diff on signed overflow instead
// of wrapping; without it the result is the plain modulo-2^WIDTH difference.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int CW = counterWidth(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_shiftA;
   logic [WIDTH-1:0] r_shiftB;
   logic [WIDTH-1:0] r_shiftR;
   logic             r_borrowQ;
   logic             r_aMsb;
   logic             r_bMsb;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrowOut;
   logic             r_ovf;

   logic             w_diffBit;
   logic             w_borrowNext;
   logic [WIDTH-1:0] w_resultNext;
   logic             w_ovf;
   logic [WIDTH-1:0] w_diffFinal;

   fs_cell u_fsCell (
      .x    (r_shiftA[0]),
      .y    (r_shiftB[0]),
      .bin  (r_borrowQ),
      .d    (w_diffBit),
      .bout (w_borrowNext)
   );

   assign w_resultNext = {w_diffBit, r_shiftR[WIDTH-1:1]};

   // Signed overflow only happens when the operand signs differ and the result
   // sign disagrees with the minuend; the operand MSBs were latched at start
   // because the shift registers no longer hold them by the last bit.
   assign w_ovf = (r_aMsb != r_bMsb) && (w_resultNext[WIDTH-1] != r_aMsb);

`ifdef SERIAL_SUB_SAT_EN
   // Clamp to the most positive or most negative value in the minuend's direction.
   assign w_diffFinal = !w_ovf ? w_resultNext :
                        (r_aMsb ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}});
`else
   assign w_diffFinal = w_resultNext;
`endif

   // Control FSM and serial datapath; result registers only update on DONE entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_shiftA    <= '0;
         r_shiftB    <= '0;
         r_shiftR    <= '0;
         r_borrowQ   <= 1'b0;
         r_aMsb      <= 1'b0;
         r_bMsb      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_diff      <= '0;
         r_borrowOut <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_shiftA  <= a;
                  r_shiftB  <= b;
                  r_shiftR  <= '0;
                  r_aMsb    <= a[WIDTH-1];
                  r_bMsb    <= b[WIDTH-1];
                  r_borrowQ <= 1'b0;
                  r_count   <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= RUN;
               end
            end
            RUN: begin
               r_shiftA  <= r_shiftA >> 1;
               r_shiftB  <= r_shiftB >> 1;
               r_shiftR  <= w_resultNext;
               r_borrowQ <= w_borrowNext;
               r_count   <= r_count + 1'b1;
               if (r_count == LAST_COUNT) begin
                  r_diff      <= w_diffFinal;
                  r_borrowOut <= w_borrowNext;
                  r_ovf       <= w_ovf;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign diff       = r_diff;
   assign borrow_out = r_borrowOut;
   assign ovf        = r_ovf;

endmodule
